// File: rtl/lock_input_conditioner.sv
// lock_input_conditioner: synchronises and debounces two push-buttons and
// turns accepted presses into a serial bit stream with a one-cycle bit_valid
// strobe. It also counts code digits and drives the downstream active-low clear.
// Optional feature macro: LOCK_COND_TIMEOUT_EN enables the idle timer. When it
// is enabled, an abandoned entry is cleared automatically.
module lock_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 64,
    parameter int CODE_LEN        = 3,
    parameter int CLR_PULSE       = 2
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       btn0_raw,
    input  logic       btn1_raw,
    output logic       data_in,
    output logic       bit_valid,
    output logic [1:0] digit_count,
    output logic       entry_done,
    output logic       lock_clr_n
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int CLR_W = $clog2(CLR_PULSE + 1);

    // Reject parameter values the datapath widths cannot represent.
    if (DEBOUNCE_CYCLES < 1 || TIMEOUT_CYCLES < 2 || CODE_LEN < 1 || CODE_LEN > 3 ||
        CLR_PULSE < 1) begin : g_param_err
        $error("lock_input_conditioner: parameter out of range");
    end

    typedef enum logic [1:0] {CLEAR, IDLE, ENTRY, DONE} state_t;

    state_t            state_q, state_d;
    logic [CLR_W-1:0]  clrcnt_q, clrcnt_d;
    logic [1:0]        sync_a_q, sync_b_q;     // bit index = button number
    logic [1:0]        db_q, db_d, db_prev_q;
    logic [DB_W-1:0]   cnt_q [2];
    logic [DB_W-1:0]   cnt_d [2];
    logic              data_q, data_d;
    logic              bv_q, bv_d;
    logic              ed_q, ed_d;
    logic [1:0]        dc_q, dc_d;
    logic [1:0]        rise;
    logic              acc0, acc1, acc;
    logic              timeout;

    // Debounce: db follows the synced level only after DEBOUNCE_CYCLES consecutive mismatches.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = '0;
            db_d[i]  = db_q[i];
            if (sync_b_q[i] != db_q[i]) begin
                if (cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    db_d[i] = sync_b_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    // Synchroniser, debounce and edge-detect registers for both buttons.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync_a_q  <= '0;
            sync_b_q  <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            cnt_q[0]  <= '0;
            cnt_q[1]  <= '0;
        end else begin
            sync_a_q  <= {btn1_raw, btn0_raw};
            sync_b_q  <= sync_a_q;
            db_q      <= db_d;
            db_prev_q <= db_q;
            cnt_q[0]  <= cnt_d[0];
            cnt_q[1]  <= cnt_d[1];
        end
    end

    // A press counts only if the other button is fully released (this also
    // drops simultaneous presses, since both db levels are then high).
    assign rise = db_q & ~db_prev_q;
    assign acc0 = rise[0] & ~db_q[1];
    assign acc1 = rise[1] & ~db_q[0];
    assign acc  = acc0 | acc1;

`ifdef LOCK_COND_TIMEOUT_EN
    localparam int TM_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TM_W-1:0] tmr_q, tmr_d;
    logic            in_entry;

    assign in_entry = (state_q == ENTRY) || (state_q == DONE);
    assign timeout  = in_entry && (tmr_q == TM_W'(TIMEOUT_CYCLES - 1));

    // Idle timer: runs only in ENTRY/DONE, restarts on every accepted press.
    always_comb begin
        tmr_d = '0;
        if (in_entry && !acc) begin
            tmr_d = tmr_q + TM_W'(1);
        end
    end

    // Idle timer register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Entry FSM: next state, forwarded bit, strobes and digit count.
    always_comb begin
        state_d  = state_q;
        clrcnt_d = '0;
        data_d   = data_q;
        bv_d     = 1'b0;
        ed_d     = 1'b0;
        dc_d     = dc_q;
        case (state_q)
            CLEAR: begin
                dc_d     = 2'd0;
                clrcnt_d = clrcnt_q + CLR_W'(1);
                if (clrcnt_q == CLR_W'(CLR_PULSE - 1)) begin
                    state_d  = IDLE;
                    clrcnt_d = '0;
                end
            end
            IDLE, ENTRY: begin
                if (acc) begin
                    bv_d   = 1'b1;
                    data_d = acc1;
                    dc_d   = (state_q == IDLE) ? 2'd1 : dc_q + 2'd1;
                    if (dc_d == 2'(CODE_LEN)) begin
                        state_d = DONE;
                        ed_d    = 1'b1;
                    end else begin
                        state_d = ENTRY;
                    end
                end else if (timeout) begin
                    state_d = CLEAR;
                    dc_d    = 2'd0;
                end
            end
            DONE: begin
                if (acc || timeout) begin
                    state_d = CLEAR;
                    dc_d    = 2'd0;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= CLEAR;
            clrcnt_q <= '0;
            data_q   <= 1'b0;
            bv_q     <= 1'b0;
            ed_q     <= 1'b0;
            dc_q     <= 2'd0;
        end else begin
            state_q  <= state_d;
            clrcnt_q <= clrcnt_d;
            data_q   <= data_d;
            bv_q     <= bv_d;
            ed_q     <= ed_d;
            dc_q     <= dc_d;
        end
    end

    assign data_in     = data_q;
    assign bit_valid   = bv_q;
    assign entry_done  = ed_q;
    assign digit_count = dc_q;
    assign lock_clr_n  = (state_q != CLEAR);

endmodule

// File: tb/tb_lock_input_conditioner.sv
// Directed testbench for lock_input_conditioner (default parameters).
module tb_lock_input_conditioner;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       btn0_raw = 1'b0;
    logic       btn1_raw = 1'b0;
    logic       data_in;
    logic       bit_valid;
    logic [1:0] digit_count;
    logic       entry_done;
    logic       lock_clr_n;

    int errors = 0;
    int checks = 0;

    // Observations gathered shortly after every rising edge.
    int cyc = 0;
    int nstrobe = 0;
    int ned = 0;
    int nlow = 0;
    int stamp = 0;
    int last_data = 0;
    int last_dc = 0;
    int last_ed = 0;
    int last_lcn = 0;

    // Snapshot taken when a press starts.
    int c0, n0, e0, l0;

    lock_input_conditioner dut (
        .clk         (clk),
        .clr         (clr),
        .btn0_raw    (btn0_raw),
        .btn1_raw    (btn1_raw),
        .data_in     (data_in),
        .bit_valid   (bit_valid),
        .digit_count (digit_count),
        .entry_done  (entry_done),
        .lock_clr_n  (lock_clr_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        #2;
        if (bit_valid) begin
            nstrobe++;
            stamp     = cyc;
            last_data = int'(data_in);
            last_dc   = int'(digit_count);
            last_ed   = int'(entry_done);
            last_lcn  = int'(lock_clr_n);
        end
        if (entry_done) ned++;
        if (!lock_clr_n) nlow++;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic mark();
        c0 = cyc; n0 = nstrobe; e0 = ned; l0 = nlow;
    endtask

    task automatic hold(input logic b0, input logic b1, input int n);
        btn0_raw = b0;
        btn1_raw = b1;
        repeat (n) @(negedge clk);
    endtask

    // Press one or both buttons for `len` cycles, then release for `gap` cycles.
    task automatic press(input logic b0, input logic b1, input int len, input int gap);
        @(negedge clk);
        mark();
        hold(b0, b1, len);
        hold(1'b0, 1'b0, gap);
    endtask

    // Expect one clean accepted press with the given bit and digit count.
    task automatic expect_bit(input string tag, input int bitv, input int dc, input int ed);
        check({tag, ".strobes"}, nstrobe - n0, 1);
        check({tag, ".data_in"}, last_data, bitv);
        check({tag, ".digit_count"}, last_dc, dc);
        check({tag, ".entry_done"}, last_ed, ed);
        check({tag, ".lock_clr_n"}, last_lcn, 1);
        check({tag, ".latency"}, stamp - c0, 7);
    endtask

    initial begin
        // Reset held for 3 cycles: every output low.
        repeat (3) @(negedge clk);
        check("rst.data_in", int'(data_in), 0);
        check("rst.bit_valid", int'(bit_valid), 0);
        check("rst.entry_done", int'(entry_done), 0);
        check("rst.digit_count", int'(digit_count), 0);
        check("rst.lock_clr_n", int'(lock_clr_n), 0);
        clr = 1'b0;
        @(negedge clk);
        check("rel.clr_n_1", int'(lock_clr_n), 0);
        @(negedge clk);
        check("rel.clr_n_2", int'(lock_clr_n), 1);
        repeat (3) @(negedge clk);

        // Three clean presses: 0, 1, 1 completes the code.
        press(1'b1, 1'b0, 10, 10);
        expect_bit("p1", 0, 1, 0);
        press(1'b0, 1'b1, 10, 10);
        expect_bit("p2", 1, 2, 0);
        press(1'b0, 1'b1, 10, 10);
        expect_bit("p3", 1, 3, 1);
        check("p3.ed_count", ned - e0, 1);

        // Press while DONE: clears downstream, nothing forwarded.
        press(1'b1, 1'b0, 10, 10);
        check("done.strobes", nstrobe - n0, 0);
        check("done.clr_low", nlow - l0, 2);
        check("done.digit_count", int'(digit_count), 0);

        // Fresh entry starts again at one digit.
        press(1'b0, 1'b1, 10, 10);
        expect_bit("new", 1, 1, 0);

        // Bouncy btn1: pulses of 1-3 cycles, then stable.
        @(negedge clk);
        mark();
        hold(1'b0, 1'b1, 2); hold(1'b0, 1'b0, 1);
        hold(1'b0, 1'b1, 3); hold(1'b0, 1'b0, 2);
        hold(1'b0, 1'b1, 1); hold(1'b0, 1'b0, 2);
        check("bounce.early", nstrobe - n0, 0);
        c0 = cyc;
        hold(1'b0, 1'b1, 10);
        hold(1'b0, 1'b0, 10);
        check("bounce.strobes", nstrobe - n0, 1);
        check("bounce.data_in", last_data, 1);
        check("bounce.digit_count", last_dc, 2);
        check("bounce.latency", stamp - c0, 7);

        // Simultaneous press, then btn0 re-pressed while btn1 stays held.
        @(negedge clk);
        mark();
        hold(1'b1, 1'b1, 8);
        hold(1'b0, 1'b1, 8);
        hold(1'b1, 1'b1, 8);
        hold(1'b0, 1'b0, 8);
        check("overlap.strobes", nstrobe - n0, 0);
        check("overlap.digit_count", int'(digit_count), 2);

        // Finish the entry, leave DONE, then a single press followed by a long idle.
        press(1'b1, 1'b0, 10, 10);
        expect_bit("p4", 0, 3, 1);
        press(1'b1, 1'b0, 10, 10);
        check("done2.digit_count", int'(digit_count), 0);
        press(1'b1, 1'b0, 10, 10);
        expect_bit("idle", 0, 1, 0);
        repeat (70) @(negedge clk);
`ifdef LOCK_COND_TIMEOUT_EN
        check("timeout.digit_count", int'(digit_count), 0);
        check("timeout.clr_low", nlow - l0, 2);
`else
        check("timeout.digit_count", int'(digit_count), 1);
        check("timeout.clr_low", nlow - l0, 0);
`endif

        // Reset in the middle of a debounce aborts the press.
        @(negedge clk);
        mark();
        hold(1'b1, 1'b0, 4);
        clr = 1'b1;
        hold(1'b1, 1'b0, 2);
        btn0_raw = 1'b0;
        clr = 1'b0;
        repeat (12) @(negedge clk);
        check("abort.strobes", nstrobe - n0, 0);
        check("abort.digit_count", int'(digit_count), 0);
        check("abort.lock_clr_n", int'(lock_clr_n), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
